red_pitaya_na_sweeper: RTL

Bus initiator that runs a network-analyzer frequency sweep against an IQ block's register interface. For each sweep point it writes the frequency word, polls until the IQ block's averaging finishes, reads back the 62-bit I/Q sums, and streams each result out through a ready/valid port. It sits between a sweep controller and one IQ block, driving the same addr/wen/ren/wdata/ack/rdata bus the IQ block answers on.

---
 rtl/red_pitaya_na_sweeper.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/red_pitaya_na_sweeper.sv
// rtl/red_pitaya_na_sweeper.sv - network-analyzer sweep bus initiator for one IQ block
module red_pitaya_na_sweeper #(
  parameter int PHASEBITS = 32,
  parameter int PTSBITS   = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [PHASEBITS-1:0] f_start_i,
  input  logic [PHASEBITS-1:0] f_step_i,
  input  logic [PTSBITS-1:0]   points_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [15:0]          m_addr_o,
  output logic                 m_wen_o,
  output logic                 m_ren_o,
  output logic [31:0]          m_wdata_o,
  input  logic                 m_ack_i,
  input  logic [31:0]          m_rdata_i,
  output logic                 pt_valid_o,
  input  logic                 pt_ready_i,
  output logic [PTSBITS-1:0]   pt_idx_o,
  output logic [61:0]          pt_i_o,
  output logic [61:0]          pt_q_o
);

  localparam int          TW        = $clog2(TIMEOUT + 1);
  localparam logic [15:0] FREQ_ADDR = 16'h0108;
  localparam logic [15:0] DATA_ADDR = 16'h0140;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, PUSH} state_t;

  state_t               state;
  state_t               state_next;
  logic [PHASEBITS-1:0] freq;
  logic [PHASEBITS-1:0] f_step;
  logic [PTSBITS-1:0]   points;
  logic [PTSBITS-1:0]   idx;
  logic [1:0]           word;
  logic [30:0]          w0, w1, w2, w3;
  logic [TW-1:0]        timer;

  logic launch;
  logic zero_sweep;
  logic capture;
  logic handshake;
  logic timed_out;
  logic expired;
  logic last_point;

  // timer counts cycles since the request; expiry leaves room for an ack on the same cycle
  assign expired    = (timer >= TW'(TIMEOUT - 1));
  assign last_point = (idx == points - PTSBITS'(1));

  // next-state and per-cycle control decisions; abort overrides everything outside IDLE
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    zero_sweep = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    timed_out  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i && !abort_i) begin
          if (points_i != '0) begin
            launch     = 1'b1;
            state_next = WR_REQ;
          end else begin
            zero_sweep = 1'b1;
          end
        end
      end
      WR_REQ: state_next = WR_WAIT;
      WR_WAIT: begin
        if (m_ack_i) begin
          state_next = RD_REQ;
        end else if (expired) begin
          timed_out  = 1'b1;
          state_next = IDLE;
        end
      end
      RD_REQ: state_next = RD_WAIT;
      RD_WAIT: begin
        if (m_ack_i) begin
          if (word == 2'd0 && m_rdata_i[31]) begin
            state_next = RD_REQ;
          end else begin
            capture    = 1'b1;
            state_next = (word == 2'd3) ? PUSH : RD_REQ;
          end
        end else if (expired) begin
          timed_out  = 1'b1;
          state_next = IDLE;
        end
      end
      PUSH: begin
        if (pt_ready_i) begin
          handshake  = 1'b1;
          state_next = last_point ? IDLE : WR_REQ;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state != IDLE && abort_i) begin
      state_next = IDLE;
      capture    = 1'b0;
      handshake  = 1'b0;
      timed_out  = 1'b0;
    end
  end

  // state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_next;
  end

  // sweep datapath: frequency/index stepping, word capture, timeout timer and status flags
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      freq    <= '0;
      f_step  <= '0;
      points  <= '0;
      idx     <= '0;
      word    <= '0;
      w0      <= '0;
      w1      <= '0;
      w2      <= '0;
      w3      <= '0;
      timer   <= '0;
      done_o  <= 1'b0;
      error_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (launch) begin
        freq    <= f_start_i;
        f_step  <= f_step_i;
        points  <= points_i;
        idx     <= '0;
        error_o <= 1'b0;
      end
      if (zero_sweep) begin
        done_o  <= 1'b1;
        error_o <= 1'b0;
      end
      if (state == WR_REQ || state == RD_REQ) timer <= TW'(1);
      else if (state == WR_WAIT || state == RD_WAIT) timer <= timer + TW'(1);
      if (state == WR_WAIT && m_ack_i) word <= '0;
      if (capture) begin
        unique case (word)
          2'd0: w0 <= m_rdata_i[30:0];
          2'd1: w1 <= m_rdata_i[30:0];
          2'd2: w2 <= m_rdata_i[30:0];
          default: w3 <= m_rdata_i[30:0];
        endcase
        word <= word + 2'd1;
      end
      if (handshake) begin
        freq <= freq + f_step;
        idx  <= idx + PTSBITS'(1);
        if (last_point) done_o <= 1'b1;
      end
      if (timed_out) error_o <= 1'b1;
    end
  end

  // bus address/data are held for the whole request-to-ack window
  always_comb begin
    m_addr_o  = '0;
    m_wdata_o = '0;
    case (state)
      WR_REQ, WR_WAIT: begin
        m_addr_o  = FREQ_ADDR;
        m_wdata_o = 32'(freq);
      end
      RD_REQ, RD_WAIT: m_addr_o = DATA_ADDR + {12'd0, word, 2'b00};
      default: ;
    endcase
  end

  assign busy_o     = (state != IDLE);
  assign m_wen_o    = (state == WR_REQ);
  assign m_ren_o    = (state == RD_REQ);
  assign pt_valid_o = (state == PUSH);
  assign pt_idx_o   = idx;
  assign pt_i_o     = {w1, w0};
  assign pt_q_o     = {w3, w2};

endmodule
